time_set_controller: RTL

- Mode/set sequencer for the hh:mm:ss time counter.
- Takes single-cycle button pulses and the 1 Hz enable, then freezes the counter while the user edits shadow hour/minute registers.
- Commits the edited time back to the counter with a one-cycle load strobe.
- Sits between the button conditioning logic and the time counter; `run_en` gates the counter's 1 Hz enable.

---
 rtl/time_set_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/time_set_controller.sv
// ---------------------------------------------------------------------------
// time_set_controller
//
// Mode/set sequencer for the hh:mm:ss time counter. Button pulses walk the
// controller through RUN -> SET_HR -> SET_MIN -> COMMIT -> RUN. While in a
// SET state the counter is frozen (run_en=0) and the user edits shadow
// hour/minute registers; COMMIT issues a one-cycle load strobe carrying the
// edited time (seconds forced to 0).
//
// Optional feature macro: AUTO_EXIT_EN
//   Defined   : an idle counter of clk_1hz_en pulses abandons an edit after
//               TIMEOUT_S button-free seconds (back to RUN, no load).
//   Undefined : SET states persist until btn_mode_p.
//
// Ports:
//   sys_clk       in   system clock
//   rst           in   synchronous reset, active-high
//   clk_1hz_en    in   one-cycle 1 Hz enable pulse
//   btn_mode_p    in   mode button pulse (wins over btn_inc_p)
//   btn_inc_p     in   increment button pulse
//   cur_minutes   in   live minutes from the counter (captured on edit entry)
//   cur_hours     in   live hours from the counter (captured on edit entry)
//   run_en        out  1 = counter may advance
//   load_en       out  one-cycle load strobe (COMMIT)
//   load_hours    out  shadow hours (valid when load_en=1)
//   load_minutes  out  shadow minutes (valid when load_en=1)
//   load_seconds  out  always 0
//   set_sel       out  00 none, 01 hours, 10 minutes
//   blink         out  blink phase for the selected field
//   dbg_state     out  current FSM state (RUN=0, SET_HR=1, SET_MIN=2, COMMIT=3)
// ---------------------------------------------------------------------------
module time_set_controller #(
   parameter int HOUR_MAX  = 23,
   parameter int MIN_MAX   = 59,
   parameter int TIMEOUT_S = 10
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       clk_1hz_en,
   input  logic       btn_mode_p,
   input  logic       btn_inc_p,
   input  logic [5:0] cur_minutes,
   input  logic [4:0] cur_hours,
   output logic       run_en,
   output logic       load_en,
   output logic [4:0] load_hours,
   output logic [5:0] load_minutes,
   output logic [5:0] load_seconds,
   output logic [1:0] set_sel,
   output logic       blink,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   localparam logic [4:0] HMAX = HOUR_MAX[4:0];
   localparam logic [5:0] MMAX = MIN_MAX[5:0];

   state_t     state_q, state_d;
   logic [4:0] hr_q, hr_d;
   logic [5:0] min_q, min_d;
   logic       blink_q, blink_d;

`ifdef AUTO_EXIT_EN
   localparam int                IDLE_W    = $clog2(TIMEOUT_S + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);
   logic [IDLE_W-1:0] idle_q, idle_d;
`endif

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= RUN;
         hr_q    <= '0;
         min_q   <= '0;
         blink_q <= 1'b0;
`ifdef AUTO_EXIT_EN
         idle_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         hr_q    <= hr_d;
         min_q   <= min_d;
         blink_q <= blink_d;
`ifdef AUTO_EXIT_EN
         idle_q  <= idle_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      hr_d    = hr_q;
      min_d   = min_q;
      blink_d = 1'b0;   // RUN and COMMIT force blink low
      unique case (state_q)
         RUN: begin
            // Inc is ignored here; mode captures the live time into the shadows.
            if (btn_mode_p) begin
               state_d = SET_HR;
               hr_d    = cur_hours;
               min_d   = cur_minutes;
               blink_d = 1'b1;
            end
         end
         SET_HR: begin
            blink_d = blink_q ^ clk_1hz_en;
            if (btn_mode_p) begin
               state_d = SET_MIN;
            end else if (btn_inc_p) begin
               // Equality compare: an out-of-range capture keeps counting at
               // field width until it wraps naturally.
               hr_d = (hr_q == HMAX) ? 5'd0 : hr_q + 5'd1;
            end
         end
         SET_MIN: begin
            if (btn_mode_p) begin
               state_d = COMMIT;
            end else begin
               blink_d = blink_q ^ clk_1hz_en;
               if (btn_inc_p) begin
                  min_d = (min_q == MMAX) ? 6'd0 : min_q + 6'd1;
               end
            end
         end
         COMMIT: begin
            // Single cycle; any button pulse landing here is dropped.
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase

`ifdef AUTO_EXIT_EN
      idle_d = '0;
      if ((state_q == SET_HR) || (state_q == SET_MIN)) begin
         if (btn_mode_p || btn_inc_p) begin
            idle_d = '0;
         end else if (clk_1hz_en) begin
            // This pulse is the one that brings the count to TIMEOUT_S.
            if (idle_q == IDLE_LAST) begin
               state_d = RUN;
               blink_d = 1'b0;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end else begin
            idle_d = idle_q;
         end
      end
`endif
   end

   assign run_en       = (state_q == RUN);
   assign load_en      = (state_q == COMMIT);
   assign load_hours   = hr_q;
   assign load_minutes = min_q;
   assign load_seconds = 6'd0;
   assign set_sel      = (state_q == SET_HR)  ? 2'b01 :
                         (state_q == SET_MIN) ? 2'b10 : 2'b00;
   assign blink        = blink_q;
   assign dbg_state    = state_q;

endmodule
